// File: rtl/pulpino_pad_pkg.sv
// Pad-ring constants: SPI pad modes and the values output pins take while rst_np is low.
package pulpino_pad_pkg;

  typedef enum logic [1:0] {
    PAD_SINGLE   = 2'b00,
    PAD_QUAD_OUT = 2'b01,
    PAD_QUAD_IN  = 2'b10
  } pad_mode_e;

  localparam int N_OUT_PADS = 11;
  localparam int N_IN_PADS  = 15;

  localparam logic       RST_UART_TX  = 1'b1;
  localparam logic       RST_UART_RTS = 1'b1;
  localparam logic       RST_UART_DTR = 1'b1;
  localparam logic       RST_GPIO     = 1'b0;
  localparam logic       RST_TDO      = 1'b0;
  localparam logic [1:0] RST_SPI_MODE = PAD_SINGLE;
  localparam logic [3:0] RST_SPI_SDO  = 4'b0000;

  // Bit order: {uart_tx, uart_rts, uart_dtr, gpio, tdo, spi_mode[1:0], spi_sdo[3:0]}
  localparam logic [N_OUT_PADS-1:0] PAD_OUT_RST = {RST_UART_TX, RST_UART_RTS, RST_UART_DTR,
                                                   RST_GPIO, RST_TDO, RST_SPI_MODE, RST_SPI_SDO};

endpackage

// File: rtl/pad_cell_io.sv
// Generic pad cell: drives the pin from the core when enabled, forced to rst_val while in reset.
module pad_cell_io (
  input  logic i_data,
  output logic o_data,
  input  logic i_oe,
  input  logic i_pad,
  output logic o_pad,
  input  logic i_rst_n,
  input  logic i_rst_val
);

  // Reset forcing is purely combinational so pins settle without a running clock.
  assign o_pad  = !i_rst_n ? i_rst_val : (i_oe ? i_data : 1'b0);
  assign o_data = i_oe ? o_pad : i_pad;

endmodule

// File: rtl/pulpino_pad_ring.sv
// PULPino chip pad ring: pin-to-core pad cells, reset synchronizer and core tie-offs.
// The core attaches on the o_core_*/i_core_* side; unused core outputs are simply not brought here.
module pulpino_pad_ring
  import pulpino_pad_pkg::*;
#(
  parameter bit USE_ZERO_RISCY = 1'b0,
  parameter bit RISCY_RV32F    = 1'b0,
  parameter bit ZERO_RV32M     = 1'b1,
  parameter bit ZERO_RV32E     = 1'b0
) (
  input  logic        clkp,
  input  logic        rst_np,
  input  logic        fetch_enable_ip,
  input  logic        spi_clk,
  input  logic        spi_cs_ip,
  output logic [1:0]  spi_mode_op,
  output logic        spi_sdo0_op,
  output logic        spi_sdo1_op,
  output logic        spi_sdo2_op,
  output logic        spi_sdo3_op,
  input  logic        spi_sdi0_ip,
  input  logic        spi_sdi1_ip,
  input  logic        spi_sdi2_ip,
  input  logic        spi_sdi3_ip,
  output logic        uart_txp,
  input  logic        uart_rxp,
  output logic        uart_rtsp,
  output logic        uart_dtrp,
  input  logic        uart_ctsp,
  input  logic        uart_dsrp,
  output logic        gpiop,
  input  logic        jtag_clk,
  input  logic        trstn_ip,
  input  logic        tms_ip,
  input  logic        tdi_ip,
  output logic        tdo_op,
  // core side
  output logic        o_core_clk,
  output logic        o_core_rst_n,
  output logic        o_core_fetch_enable,
  output logic        o_core_spi_clk,
  output logic        o_core_spi_cs,
  output logic [3:0]  o_core_spi_sdi,
  output logic        o_core_uart_rx,
  output logic        o_core_uart_cts,
  output logic        o_core_uart_dsr,
  output logic        o_core_tck,
  output logic        o_core_trstn,
  output logic        o_core_tms,
  output logic        o_core_tdi,
  output logic        o_core_testmode,
  output logic        o_core_clk_sel,
  output logic [31:0] o_core_gpio_in,
  output logic [3:0]  o_core_spim_sdi,
  output logic        o_core_scl,
  output logic        o_core_sda,
  output logic [3:0]  o_core_cfg,
  input  logic [1:0]  i_core_spi_mode,
  input  logic [3:0]  i_core_spi_sdo,
  input  logic        i_core_uart_tx,
  input  logic        i_core_uart_rts,
  input  logic        i_core_uart_dtr,
  input  logic        i_core_gpio_out0,
  input  logic        i_core_tdo
);

  logic [1:0]            r_rst_sync;
  logic [N_OUT_PADS-1:0] w_out_core;
  logic [N_OUT_PADS-1:0] w_out_pin;
  logic [N_OUT_PADS-1:0] w_unused_out_loop;
  logic [N_IN_PADS-1:0]  w_in_pin;
  logic [N_IN_PADS-1:0]  w_in_core;
  logic [N_IN_PADS-1:0]  w_unused_in_pad;

  always_ff @(posedge clkp or negedge rst_np) begin
    if (!rst_np) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign o_core_rst_n = r_rst_sync[1];

  assign w_out_core = {i_core_uart_tx, i_core_uart_rts, i_core_uart_dtr, i_core_gpio_out0,
                       i_core_tdo, i_core_spi_mode, i_core_spi_sdo};

  // Output pads are forced from raw rst_np, not the synchronized reset, so pins react at once.
  for (genvar k = 0; k < N_OUT_PADS; k++) begin : g_out_pad
    pad_cell_io u_pad (
      .i_data    (w_out_core[k]),
      .o_data    (w_unused_out_loop[k]),
      .i_oe      (1'b1),
      .i_pad     (1'b0),
      .o_pad     (w_out_pin[k]),
      .i_rst_n   (rst_np),
      .i_rst_val (PAD_OUT_RST[k])
    );
  end

  assign {uart_txp, uart_rtsp, uart_dtrp, gpiop, tdo_op, spi_mode_op,
          spi_sdo3_op, spi_sdo2_op, spi_sdo1_op, spi_sdo0_op} = w_out_pin;

  assign w_in_pin = {clkp, fetch_enable_ip, spi_clk, spi_cs_ip,
                     spi_sdi3_ip, spi_sdi2_ip, spi_sdi1_ip, spi_sdi0_ip,
                     uart_rxp, uart_ctsp, uart_dsrp, jtag_clk, trstn_ip, tms_ip, tdi_ip};

  for (genvar k = 0; k < N_IN_PADS; k++) begin : g_in_pad
    pad_cell_io u_pad (
      .i_data    (1'b0),
      .o_data    (w_in_core[k]),
      .i_oe      (1'b0),
      .i_pad     (w_in_pin[k]),
      .o_pad     (w_unused_in_pad[k]),
      .i_rst_n   (1'b1),
      .i_rst_val (1'b0)
    );
  end

  assign {o_core_clk, o_core_fetch_enable, o_core_spi_clk, o_core_spi_cs, o_core_spi_sdi,
          o_core_uart_rx, o_core_uart_cts, o_core_uart_dsr,
          o_core_tck, o_core_trstn, o_core_tms, o_core_tdi} = w_in_core;

  assign o_core_testmode = 1'b0;
  assign o_core_clk_sel  = 1'b0;
  assign o_core_gpio_in  = 32'h0000_0000;
  assign o_core_spim_sdi = 4'b0000;
  assign o_core_scl      = 1'b1;
  assign o_core_sda      = 1'b1;
  assign o_core_cfg      = {ZERO_RV32E, ZERO_RV32M, RISCY_RV32F, USE_ZERO_RISCY};

endmodule

// File: tb/tb_pulpino_pad_ring.sv
// Directed bench for the pad ring; the bench plays the core on the o_core_*/i_core_* side.
module tb_pulpino_pad_ring;

  logic clkp = 1'b0;
  logic rst_np = 1'b0;
  logic fetch_enable_ip = 1'b0, spi_clk = 1'b0, spi_cs_ip = 1'b1;
  logic spi_sdi0_ip = 1'b0, spi_sdi1_ip = 1'b0, spi_sdi2_ip = 1'b0, spi_sdi3_ip = 1'b0;
  logic uart_rxp = 1'b1, uart_ctsp = 1'b1, uart_dsrp = 1'b1;
  logic jtag_clk = 1'b0, trstn_ip = 1'b0, tms_ip = 1'b0, tdi_ip = 1'b0;
  logic [1:0] spi_mode_op;
  logic spi_sdo0_op, spi_sdo1_op, spi_sdo2_op, spi_sdo3_op;
  logic uart_txp, uart_rtsp, uart_dtrp, gpiop, tdo_op;

  logic o_core_clk, o_core_rst_n, o_core_fetch_enable, o_core_spi_clk, o_core_spi_cs;
  logic [3:0] o_core_spi_sdi;
  logic o_core_uart_rx, o_core_uart_cts, o_core_uart_dsr;
  logic o_core_tck, o_core_trstn, o_core_tms, o_core_tdi;
  logic o_core_testmode, o_core_clk_sel;
  logic [31:0] o_core_gpio_in;
  logic [3:0] o_core_spim_sdi;
  logic o_core_scl, o_core_sda;
  logic [3:0] o_core_cfg;

  logic [1:0] i_core_spi_mode = 2'b00;
  logic [3:0] i_core_spi_sdo = 4'b0000;
  logic i_core_uart_tx = 1'b1, i_core_uart_rts = 1'b1, i_core_uart_dtr = 1'b1;
  logic i_core_gpio_out0 = 1'b0, i_core_tdo = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  pulpino_pad_ring dut (
    .clkp(clkp), .rst_np(rst_np), .fetch_enable_ip(fetch_enable_ip),
    .spi_clk(spi_clk), .spi_cs_ip(spi_cs_ip), .spi_mode_op(spi_mode_op),
    .spi_sdo0_op(spi_sdo0_op), .spi_sdo1_op(spi_sdo1_op),
    .spi_sdo2_op(spi_sdo2_op), .spi_sdo3_op(spi_sdo3_op),
    .spi_sdi0_ip(spi_sdi0_ip), .spi_sdi1_ip(spi_sdi1_ip),
    .spi_sdi2_ip(spi_sdi2_ip), .spi_sdi3_ip(spi_sdi3_ip),
    .uart_txp(uart_txp), .uart_rxp(uart_rxp), .uart_rtsp(uart_rtsp),
    .uart_dtrp(uart_dtrp), .uart_ctsp(uart_ctsp), .uart_dsrp(uart_dsrp),
    .gpiop(gpiop), .jtag_clk(jtag_clk), .trstn_ip(trstn_ip), .tms_ip(tms_ip),
    .tdi_ip(tdi_ip), .tdo_op(tdo_op),
    .o_core_clk(o_core_clk), .o_core_rst_n(o_core_rst_n),
    .o_core_fetch_enable(o_core_fetch_enable), .o_core_spi_clk(o_core_spi_clk),
    .o_core_spi_cs(o_core_spi_cs), .o_core_spi_sdi(o_core_spi_sdi),
    .o_core_uart_rx(o_core_uart_rx), .o_core_uart_cts(o_core_uart_cts),
    .o_core_uart_dsr(o_core_uart_dsr), .o_core_tck(o_core_tck),
    .o_core_trstn(o_core_trstn), .o_core_tms(o_core_tms), .o_core_tdi(o_core_tdi),
    .o_core_testmode(o_core_testmode), .o_core_clk_sel(o_core_clk_sel),
    .o_core_gpio_in(o_core_gpio_in), .o_core_spim_sdi(o_core_spim_sdi),
    .o_core_scl(o_core_scl), .o_core_sda(o_core_sda), .o_core_cfg(o_core_cfg),
    .i_core_spi_mode(i_core_spi_mode), .i_core_spi_sdo(i_core_spi_sdo),
    .i_core_uart_tx(i_core_uart_tx), .i_core_uart_rts(i_core_uart_rts),
    .i_core_uart_dtr(i_core_uart_dtr), .i_core_gpio_out0(i_core_gpio_out0),
    .i_core_tdo(i_core_tdo)
  );

  always #20 clkp = ~clkp;

  // {uart_tx, rts, dtr, gpio, tdo, spi_mode[1:0], sdo[3:0]}
  function automatic logic [10:0] pins_out();
    return {uart_txp, uart_rtsp, uart_dtrp, gpiop, tdo_op, spi_mode_op,
            spi_sdo3_op, spi_sdo2_op, spi_sdo1_op, spi_sdo0_op};
  endfunction

  task automatic drive_core(input logic [10:0] v);
    {i_core_uart_tx, i_core_uart_rts, i_core_uart_dtr, i_core_gpio_out0, i_core_tdo,
     i_core_spi_mode, i_core_spi_sdo} = v;
  endtask

  task automatic drive_in(input logic [13:0] v);
    {fetch_enable_ip, spi_clk, spi_cs_ip, spi_sdi3_ip, spi_sdi2_ip, spi_sdi1_ip, spi_sdi0_ip,
     uart_rxp, uart_ctsp, uart_dsrp, jtag_clk, trstn_ip, tms_ip, tdi_ip} = v;
  endtask

  function automatic logic [13:0] core_in();
    return {o_core_fetch_enable, o_core_spi_clk, o_core_spi_cs, o_core_spi_sdi,
            o_core_uart_rx, o_core_uart_cts, o_core_uart_dsr,
            o_core_tck, o_core_trstn, o_core_tms, o_core_tdi};
  endfunction

  task automatic test_reset();
    logic [10:0] exp_rst;
    logic [47:0] ties;
    exp_rst = 11'b111_00_00_0000;
    drive_core(11'b000_11_11_1111);  // core drives the opposite of every forced value
    #500;
    n_tests++;
    if (pins_out() !== exp_rst) begin
      n_fail++; $display("FAIL reset_pins got=%b want=%b", pins_out(), exp_rst);
    end
    n_tests++;
    if (o_core_rst_n !== 1'b0) begin
      n_fail++; $display("FAIL reset_core_rst got=%b want=0", o_core_rst_n);
    end
    ties = {o_core_testmode, o_core_clk_sel, o_core_gpio_in, o_core_spim_sdi,
            o_core_scl, o_core_sda, o_core_cfg};
    n_tests++;
    if (ties !== {2'b00, 32'h0, 4'h0, 2'b11, 4'b0100}) begin
      n_fail++; $display("FAIL tie_offs got=%h want=%h", ties, {2'b00, 32'h0, 4'h0, 2'b11, 4'b0100});
    end
  endtask

  task automatic test_release();
    @(negedge clkp);
    rst_np = 1'b1;
    #1;
    n_tests++;
    if (pins_out() !== 11'b000_11_11_1111) begin
      n_fail++; $display("FAIL release_pins_follow got=%b want=%b", pins_out(), 11'b000_11_11_1111);
    end
    n_tests++;
    if (o_core_rst_n !== 1'b0) begin
      n_fail++; $display("FAIL release_edge0 got=%b want=0", o_core_rst_n);
    end
    @(posedge clkp); #1;
    n_tests++;
    if (o_core_rst_n !== 1'b0) begin
      n_fail++; $display("FAIL release_edge1 got=%b want=0", o_core_rst_n);
    end
    @(posedge clkp); #1;
    n_tests++;
    if (o_core_rst_n !== 1'b1) begin
      n_fail++; $display("FAIL release_edge2 got=%b want=1", o_core_rst_n);
    end
  endtask

  task automatic test_passthrough();
    logic [10:0] vec [6];
    vec = '{11'b000_00_00_0000, 11'b111_11_11_1111, 11'b101_01_01_0101,
            11'b010_10_10_1010, 11'b100_00_01_1000, 11'b001_10_00_0001};
    foreach (vec[k]) begin
      drive_core(vec[k]);
      #1;
      n_tests++;
      if (pins_out() !== vec[k]) begin
        n_fail++; $display("FAIL passthrough[%0d] got=%b want=%b", k, pins_out(), vec[k]);
      end
    end
  endtask

  task automatic test_inputs();
    logic [13:0] vec [4];
    vec = '{14'h0000, 14'h3FFF, 14'h1555, 14'h2AAA};
    foreach (vec[k]) begin
      drive_in(vec[k]);
      #1;
      n_tests++;
      if (core_in() !== vec[k]) begin
        n_fail++; $display("FAIL input_pad[%0d] got=%h want=%h", k, core_in(), vec[k]);
      end
    end
  endtask

  task automatic test_spi_qpi();
    logic [1:0] modes [4];
    modes = '{2'b10, 2'b01, 2'b10, 2'b00};
    foreach (modes[k]) begin
      i_core_spi_mode = modes[k];
      i_core_spi_sdo  = 4'(k * 5 + 3);
      @(negedge clkp);
      n_tests++;
      if ({spi_mode_op, spi_sdo3_op, spi_sdo2_op, spi_sdo1_op, spi_sdo0_op} !== {modes[k], 4'(k * 5 + 3)}) begin
        n_fail++; $display("FAIL spi_qpi[%0d] got=%b%b%b%b%b want=%b%b", k, spi_mode_op,
                           spi_sdo3_op, spi_sdo2_op, spi_sdo1_op, spi_sdo0_op, modes[k], 4'(k * 5 + 3));
      end
    end
  endtask

  task automatic test_clock();
    @(posedge clkp); #1;
    n_tests++;
    if (o_core_clk !== 1'b1) begin
      n_fail++; $display("FAIL core_clk_high got=%b want=1", o_core_clk);
    end
    @(negedge clkp); #1;
    n_tests++;
    if (o_core_clk !== 1'b0) begin
      n_fail++; $display("FAIL core_clk_low got=%b want=0", o_core_clk);
    end
  endtask

  task automatic test_midrun_reset();
    drive_core(11'b011_01_00_1001);
    i_core_gpio_out0 = 1'b1;
    i_core_uart_tx   = 1'b0;
    drive_in(14'h2004);  // fetch enable high, trstn high
    #1;
    n_tests++;
    if ({gpiop, uart_txp} !== 2'b10) begin
      n_fail++; $display("FAIL midrun_pre got=%b want=10", {gpiop, uart_txp});
    end
    @(posedge clkp); #7;
    rst_np = 1'b0;
    #1;
    n_tests++;
    if (pins_out() !== 11'b111_00_00_0000) begin
      n_fail++; $display("FAIL midrun_forced got=%b want=%b", pins_out(), 11'b111_00_00_0000);
    end
    n_tests++;
    if (o_core_rst_n !== 1'b0) begin
      n_fail++; $display("FAIL midrun_core_rst got=%b want=0", o_core_rst_n);
    end
    n_tests++;
    if ({o_core_trstn, o_core_fetch_enable} !== 2'b11) begin
      n_fail++; $display("FAIL midrun_trstn_fetch got=%b want=11", {o_core_trstn, o_core_fetch_enable});
    end
    repeat (3) @(posedge clkp);
    #1;
    n_tests++;
    if (o_core_rst_n !== 1'b0) begin
      n_fail++; $display("FAIL midrun_held got=%b want=0", o_core_rst_n);
    end
    // re-boot: same two-edge release as power-on
    drive_core(11'b000_11_11_1111);
    test_release();
    drive_core(11'b110_10_00_0110);
    #1;
    n_tests++;
    if (pins_out() !== 11'b110_10_00_0110) begin
      n_fail++; $display("FAIL reboot_pins got=%b want=%b", pins_out(), 11'b110_10_00_0110);
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_passthrough();
    test_inputs();
    test_spi_qpi();
    test_clock();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
